// File: rtl/lcd_driver.sv
// lcd_driver: responder end of the decoder-to-LCD print interface.
// Runs the HD44780 power-on init by itself, then prints one character per
// strt/lcd_done handshake, optionally moving the cursor first.
// Optional feature macro: LCD_HEX_EN (print the byte as two uppercase hex digits).
module lcd_driver #(
  parameter int unsigned PWRUP_CYC    = 750000,
  parameter int unsigned E_PULSE_CYC  = 12,
  parameter int unsigned CMD_WAIT_CYC = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       strt,
  input  logic [7:0] lcd_data,
  input  logic [7:0] data_loc,
  input  logic       loc_req,
  output logic       lcd_done,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);

`ifdef LCD_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  localparam int unsigned MAX_A   = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
  localparam int unsigned MAX_B   = (CMD_WAIT_CYC > E_PULSE_CYC) ? CMD_WAIT_CYC : E_PULSE_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_SET_ADDR, S_WR_CHAR, S_DONE, S_REARM
  } state_t;

  // Sub-phases of one bus write, shared by every writing state.
  typedef enum logic [1:0] {P_SETUP, P_PULSE, P_WAIT} phase_t;

  state_t           state_q, state_d;
  phase_t           ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             nib_q, nib_d;
  logic [7:0]       chr_q, chr_d;
  logic [4:0]       loc_q, loc_d;
  logic             wr_fin;
  logic [CNT_W-1:0] wait_last;
  logic             done_d, busy_d, init_done_d, rs_d, e_d;
  logic [7:0]       db_d;

  // Column bits [7:5] of the location carry no meaning.
  logic unused_loc_bits;
  assign unused_loc_bits = ^data_loc[7:5];

  assign lcd_rw = 1'b0;

  function automatic logic is_write(input state_t st);
    return (st == S_INIT) || (st == S_SET_ADDR) || (st == S_WR_CHAR);
  endfunction

  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte placed on the bus for a given write state.
  function automatic logic [7:0] write_byte(input state_t st, input logic [1:0] idx,
                                            input logic nib, input logic [7:0] chr,
                                            input logic [4:0] loc);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      S_INIT: begin
        case (idx)
          2'd0:    b = 8'h38;
          2'd1:    b = 8'h0C;
          2'd2:    b = 8'h01;
          default: b = 8'h06;
        endcase
      end
      S_SET_ADDR: b = {1'b1, loc[4], 2'b00, loc[3:0]};
      S_WR_CHAR: begin
        if (HEX_EN) b = hex_digit(nib ? chr[3:0] : chr[7:4]);
        else        b = chr;
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // The clear-display command needs the long settle time.
  assign wait_last = ((state_q == S_INIT) && (idx_q == 2'd2)) ? CNT_W'(CLR_WAIT_CYC - 1)
                                                              : CNT_W'(CMD_WAIT_CYC - 1);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    nib_d       = nib_q;
    chr_d       = chr_q;
    loc_d       = loc_q;
    init_done_d = init_done;
    wr_fin      = 1'b0;

    if (is_write(state_q)) begin
      case (ph_q)
        P_SETUP: begin
          ph_d  = P_PULSE;
          cnt_d = '0;
        end
        P_PULSE: begin
          if (cnt_q == CNT_W'(E_PULSE_CYC - 1)) begin
            ph_d  = P_WAIT;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (cnt_q == wait_last) begin
            wr_fin = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == CNT_W'(PWRUP_CYC - 1)) begin
          state_d = S_INIT;
          ph_d    = P_SETUP;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_INIT: begin
        if (wr_fin) begin
          if (idx_q == 2'd3) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
            ph_d  = P_SETUP;
          end
        end
      end
      S_IDLE: begin
        if (strt) begin
          chr_d   = lcd_data;
          loc_d   = data_loc[4:0];
          nib_d   = 1'b0;
          ph_d    = P_SETUP;
          cnt_d   = '0;
          state_d = loc_req ? S_SET_ADDR : S_WR_CHAR;
        end
      end
      S_SET_ADDR: begin
        if (wr_fin) begin
          state_d = S_WR_CHAR;
          ph_d    = P_SETUP;
        end
      end
      S_WR_CHAR: begin
        if (wr_fin) begin
          if (HEX_EN && !nib_q) begin
            nib_d = 1'b1;
            ph_d  = P_SETUP;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_REARM;
      S_REARM: if (!strt) state_d = S_IDLE;
      default: state_d = S_PWRUP;
    endcase

    // Registered outputs follow the state being entered.
    e_d  = is_write(state_d) && (ph_d == P_PULSE);
    rs_d = lcd_rs;
    db_d = lcd_db;
    if (is_write(state_d)) begin
      rs_d = (state_d == S_WR_CHAR);
      db_d = write_byte(state_d, idx_d, nib_d, chr_d, loc_d);
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any write in flight.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_PWRUP;
      ph_q      <= P_SETUP;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      nib_q     <= 1'b0;
      chr_q     <= 8'h00;
      loc_q     <= 5'd0;
      lcd_done  <= 1'b0;
      busy      <= 1'b1;
      init_done <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_db    <= 8'h00;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      nib_q     <= nib_d;
      chr_q     <= chr_d;
      loc_q     <= loc_d;
      lcd_done  <= done_d;
      busy      <= busy_d;
      init_done <= init_done_d;
      lcd_rs    <= rs_d;
      lcd_e     <= e_d;
      lcd_db    <= db_d;
    end
  end

endmodule

// File: tb/tb_lcd_driver.sv
// tb_lcd_driver: random print requests against a write-list reference model,
// with a scoreboard monitor checking bus writes and lcd_done timing.
module tb_lcd_driver;

  localparam int PWRUP = 10;
  localparam int EPUL  = 2;
  localparam int CMDW  = 3;
  localparam int CLRW  = 8;
  localparam int WRC   = 1 + EPUL + CMDW;
  localparam int INIT_LEN = PWRUP + 3 * WRC + (1 + EPUL + CLRW);

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       strt;
  logic [7:0] lcd_data, data_loc;
  logic       loc_req;
  logic       lcd_done, busy, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;

  lcd_driver #(.PWRUP_CYC(PWRUP), .E_PULSE_CYC(EPUL), .CMD_WAIT_CYC(CMDW),
               .CLR_WAIT_CYC(CLRW)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .strt(strt), .lcd_data(lcd_data),
    .data_loc(data_loc), .loc_req(loc_req), .lcd_done(lcd_done), .busy(busy),
    .init_done(init_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_db(lcd_db)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic rs; logic [7:0] db; int gap; int at; } wr_t;
  typedef struct { int cyc; bit rel_init; int nwr; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  int n_chk = 0;
  int n_fail = 0;
  int exp_init_cyc = -1;
  int init_rise_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic rs, input logic [7:0] db, input int gap, input int at);
    wr_t w;
    w.rs = rs; w.db = db; w.gap = gap; w.at = at;
    wq.push_back(w);
  endtask

`ifdef LCD_HEX_EN
  function automatic logic [7:0] hexd(input logic [3:0] n);
    if (n < 4'd10) return 8'd48 + {4'd0, n};
    return 8'd55 + {4'd0, n};
  endfunction
`endif

  // Expected init writes, relative to the cycle count at reset release.
  task automatic push_init(input int r);
    push_wr(1'b0, 8'h38, 0, r + PWRUP + 1);
    push_wr(1'b0, 8'h0C, CMDW + 1, -1);
    push_wr(1'b0, 8'h01, CMDW + 1, -1);
    push_wr(1'b0, 8'h06, CLRW + 1, -1);
    exp_init_cyc = r + INIT_LEN;
  endtask

  // Expected writes for one print; returns how many writes it takes.
  task automatic push_print(input logic [7:0] d, input logic [7:0] loc, input logic lreq,
                            output int n);
    n = 0;
    if (lreq) begin
      push_wr(1'b0, 8'h80 + (loc[4] ? 8'h40 : 8'h00) + {4'h0, loc[3:0]}, 0, -1);
      n++;
    end
`ifdef LCD_HEX_EN
    push_wr(1'b1, hexd(d[7:4]), (n > 0) ? CMDW + 1 : 0, -1);
    push_wr(1'b1, hexd(d[3:0]), CMDW + 1, -1);
    n += 2;
`else
    push_wr(1'b1, d, (n > 0) ? CMDW + 1 : 0, -1);
    n++;
`endif
  endtask

  // Monitor: checks each write strobe and each lcd_done against the queues.
  bit in_pulse = 0, have_fall = 0, prev_done = 0, prev_init = 0;
  int rise_cyc = 0, fall_cyc = 0;
  logic rs_cap;
  logic [7:0] db_cap;
  always @(negedge clk) begin
    if (!sys_rst_n) begin
      in_pulse = 0; have_fall = 0; prev_done = 0; prev_init = 0;
    end else begin
      if (lcd_e && !in_pulse) begin
        wr_t w;
        in_pulse = 1; rise_cyc = cyc; rs_cap = lcd_rs; db_cap = lcd_db;
        check("rw_low", 32'(lcd_rw), 32'd0);
        if (wq.size() == 0) begin
          check("unexpected_write", 32'(lcd_db), 32'hFFFF_FFFF);
        end else begin
          w = wq.pop_front();
          check("wr_rs", 32'(lcd_rs), 32'(w.rs));
          check("wr_db", 32'(lcd_db), 32'(w.db));
          if (w.gap > 0) check("wr_gap", have_fall ? 32'(cyc - fall_cyc) : 32'hFFFF_FFFF, 32'(w.gap));
          if (w.at >= 0) check("wr_first_at", 32'(cyc), 32'(w.at));
        end
      end else if (!lcd_e && in_pulse) begin
        in_pulse = 0; have_fall = 1; fall_cyc = cyc;
        check("e_width", 32'(cyc - rise_cyc), 32'(EPUL));
        check("db_stable", {23'd0, lcd_rs, lcd_db}, {23'd0, rs_cap, db_cap});
      end
      if (init_done && !prev_init) begin
        init_rise_cyc = cyc;
        check("init_done_at", 32'(cyc), 32'(exp_init_cyc));
      end
      if (lcd_done) begin
        if (prev_done) begin
          check("done_width", 32'd2, 32'd1);
        end else if (dq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          dn_t d;
          int ex;
          d = dq.pop_front();
          ex = d.rel_init ? init_rise_cyc + 1 + WRC * d.nwr : d.cyc;
          check("done_at", 32'(cyc), 32'(ex));
          check("writes_before_done", 32'(wq.size()), 32'd0);
        end
      end
      prev_done = lcd_done;
      prev_init = init_done;
    end
  end

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (lcd_done) begin ok = 1; break; end
    end
    check("done_timeout", 32'(ok), 32'd1);
  endtask

  // One requester transaction; hold keeps strt up one extra cycle past lcd_done.
  task automatic do_print(input logic [7:0] d, input logic [7:0] loc, input logic lreq,
                          input bit hold);
    int n;
    dn_t e;
    @(negedge clk);
    lcd_data = d; data_loc = loc; loc_req = lreq; strt = 1'b1;
    push_print(d, loc, lreq, n);
    e.cyc = cyc + 1 + WRC * n; e.rel_init = 0; e.nwr = n;
    dq.push_back(e);
    @(negedge clk);
    lcd_data = 8'($urandom); data_loc = 8'($urandom); loc_req = 1'($urandom);
    wait_done();
    @(negedge clk);
    if (hold) begin
      check("rearm_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("hold_busy", 32'(busy), 32'd1);
    end
    strt = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    dn_t e;
    bit ok;
    sys_rst_n = 1'b0; strt = 1'b0; lcd_data = 8'h00; data_loc = 8'h00; loc_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(lcd_done), 32'd0);
    check("rst_init", 32'(init_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_rw", 32'(lcd_rw), 32'd0);
    check("rst_e", 32'(lcd_e), 32'd0);
    check("rst_db", 32'(lcd_db), 32'd0);

    push_init(cyc);
    sys_rst_n = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (init_done) begin ok = 1; break; end
    end
    check("init_timeout", 32'(ok), 32'd1);
    check("init_writes_left", 32'(wq.size()), 32'd0);
    check("idle_after_init", 32'(busy), 32'd0);

    do_print(8'h41, 8'h13, 1'b1, 1'b0);
    do_print(8'h5A, 8'h00, 1'b0, 1'b0);
    do_print(8'h3A, 8'h00, 1'b0, 1'b0);
    do_print(8'($urandom), 8'($urandom), 1'b1, 1'b1);
    do_print(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      do_print(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));

    // Reset in the middle of a strobe, request kept pending across re-init.
    @(negedge clk);
    lcd_data = 8'h7E; data_loc = 8'h05; loc_req = 1'b1; strt = 1'b1;
    push_print(8'h7E, 8'h05, 1'b1, n);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lcd_e) begin ok = 1; break; end
    end
    check("e_seen", 32'(ok), 32'd1);
    #1 sys_rst_n = 1'b0;
    #1;
    check("abort_e", 32'(lcd_e), 32'd0);
    check("abort_done", 32'(lcd_done), 32'd0);
    check("abort_init", 32'(init_done), 32'd0);
    wq.delete(); dq.delete();
    lcd_data = 8'($urandom); data_loc = 8'($urandom); loc_req = 1'($urandom);
    repeat (2) @(negedge clk);
    push_init(cyc);
    push_print(lcd_data, data_loc, loc_req, n);
    e.cyc = 0; e.rel_init = 1; e.nwr = n;
    dq.push_back(e);
    sys_rst_n = 1'b1;
    wait_done();
    @(negedge clk);
    strt = 1'b0;
    @(negedge clk);
    check("pending_idle_busy", 32'(busy), 32'd0);

    do_print(8'($urandom), 8'($urandom), 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("final_writes_left", 32'(wq.size()), 32'd0);
    check("final_dones_left", 32'(dq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
